mod_addsub_acc_pipe: RTL and testbench
======================================

// Module: mod_addsub_acc_pipe
// PURPOSE
//  Multi-lane modular add/subtract/accumulate unit with a two-stage pipeline and a valid/ready handshake.
//  Every lane computes its result modulo a shared modulus iQ.
//  Per-lane accumulators support running modular sums and differences for NTT/RNS datapaths.
//  Sits between operand fetch and the butterfly/reduction stages; accepts one vector per cycle.
// PARAMETERS
//  BITWIDTH  32  width of each lane operand, of iQ and of each result
//  LANES     4   number of independent lanes; all lanes share iQ and iMode
// PORTS
//  iClk    in   1               clock, rising edge
//  iRst    in   1               asynchronous reset, active-high
//  iValid  in   1               input vector valid
//  oReady  out  1               unit can accept an input this cycle
//  iMode   in   2               op: 0 ADD, 1 SUB, 2 ACC_ADD, 3 ACC_SUB
//  iClr    in   1               synchronous clear of all lane accumulators
//  iData0  in   LANES*BITWIDTH  operand a; lane k = [k*BITWIDTH +: BITWIDTH]
//  iData1  in   LANES*BITWIDTH  operand b (ignored in ACC modes)
//  iQ      in   BITWIDTH        modulus, 2 <= iQ < 2^BITWIDTH; sampled per accepted vector
//  oValid  out  1               result vector valid
//  iReady  in   1               downstream accepts the result
//  oData   out  LANES*BITWIDTH  result vector
//  oErr    out  LANES           per-lane range flag (only with MOD_RANGE_CHECK_EN)
// BEHAVIOUR
//  - Reset (asynchronous on iRst high): both stage valids = 0, oValid = 0, oData = 0, all accumulators = 0, oErr = 0.
//  - Pipeline control: adv = !oValid | iReady; oReady = adv; accept = iValid & adv.
//    When adv = 0, all stages hold and no accumulator changes.
//  - Stage 1 registers the modular result on adv; its valid flag takes the value of accept.
//    Stage 2 (output) registers stage 1 on adv.
//  - Latency: 2 cycles from accept to oValid. Throughput: 1 vector per cycle with no stall.
//  - Operands are required to lie in [0, iQ).
//  - ADD: s = a + b, computed in BITWIDTH+1 bits; r = (s >= iQ) ? s - iQ : s.
//  - SUB: d = a - b, computed in BITWIDTH+1 bits; r = borrow ? d + iQ : d. Result truncated to BITWIDTH.
//  - ACC_ADD: r = (acc + a) mod iQ. ACC_SUB: r = (acc - a) mod iQ. Same correction rules as ADD/SUB.
//    On accept, acc <= r and r is also emitted. Back-to-back ACC ops see the updated acc; no bubble.
//  - ADD/SUB never touch the accumulators.
//  - iClr alone: all acc <= 0 on the next edge, regardless of adv.
//  - iClr with an accepted ACC op: the op uses acc = 0 (clear, then accumulate). acc <= r.
//  - Reset mid-operation: in-flight results are discarded; oValid drops asynchronously.
//  - iMode, iQ and the operands are don't-care when iValid = 0.
// CONFIGURATION
//  MOD_RANGE_CHECK_EN defined:
//  - oErr exists. oErr[k] = 1 when operand a >= iQ, or (ADD/SUB only) b >= iQ. Evaluated at accept.
//  - oErr[k] travels with its result and is qualified by oValid.
//  - The lane result is still computed by the normal rule and is not saturated.
//  - A flagged ACC op still updates the accumulator.
//  MOD_RANGE_CHECK_EN not defined:
//  - oErr port and its logic are absent.
//  - Out-of-range operands give an unspecified result; no flag.
// STRUCTURE
//  - Shared package mod_pkg:
//    - mode constants MOD_ADD = 2'd0, MOD_SUB = 2'd1, MOD_ACC_ADD = 2'd2, MOD_ACC_SUB = 2'd3.
//    - lane slice helper function.
//  - Sub-module mod_addsub_lane: combinational single-lane modular add/sub, including the range check.
//    It is instantiated LANES times via generate.
//  - Top level: handshake, the two pipeline registers, and the accumulator registers.
// TESTING  (BITWIDTH=8, LANES=2, iQ=17)
//  - ADD: lane0 10+9, lane1 16+0 -> 2 cycles later oValid=1, oData lanes {2,16}.
//  - SUB: lane0 3-5, lane1 5-3 -> {15,2}. Back-to-back ADD/SUB at full rate gives one result per cycle.
//  - ACC_ADD a=16 for three consecutive cycles from reset -> outputs 16, 15, 14.
//    Then ACC_SUB a=15 -> 16. Accumulator wrap verified.
//  - Backpressure: hold iReady=0 for 3 cycles with iValid=1.
//    -> oReady=0 once the pipe is full, oData stable, no lost or duplicated vectors, accumulators frozen.
//  - iClr with accepted ACC_ADD a=7 while acc=9 -> output 7, acc=7.
//    iClr alone -> the next ACC_ADD a=1 gives 1.
//  - Assert iRst with 2 vectors in flight -> oValid=0 immediately. The first post-reset ACC_ADD a=4 gives 4.
//    With MOD_RANGE_CHECK_EN: ADD a=17 b=0 -> oErr[0]=1.

Source files
------------

// File: rtl/mod_pkg.sv
// rtl/mod_pkg.sv - op codes and lane slicing helper shared by the modular add/sub pipe
package mod_pkg;

   typedef enum logic [1:0] {
      MOD_ADD     = 2'd0,
      MOD_SUB     = 2'd1,
      MOD_ACC_ADD = 2'd2,
      MOD_ACC_SUB = 2'd3
   } mod_op_e;

   // Lane k occupies bits [k*width +: width] of a packed lane vector.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/mod_addsub_acc_pipe_if.sv
// rtl/mod_addsub_acc_pipe_if.sv - operand/result handshake bundle for mod_addsub_acc_pipe
// oErr is present only when MOD_RANGE_CHECK_EN is defined.
interface mod_addsub_acc_pipe_if #(
   parameter int BITWIDTH = 32,
   parameter int LANES    = 4
);
   logic                      iValid;
   logic                      oReady;
   logic [1:0]                iMode;
   logic                      iClr;
   logic [LANES*BITWIDTH-1:0] iData0;
   logic [LANES*BITWIDTH-1:0] iData1;
   logic [BITWIDTH-1:0]       iQ;
   logic                      oValid;
   logic                      iReady;
   logic [LANES*BITWIDTH-1:0] oData;
`ifdef MOD_RANGE_CHECK_EN
   logic [LANES-1:0]          oErr;
`endif

   modport master (
      output iValid, iMode, iClr, iData0, iData1, iQ, iReady,
      input  oReady, oValid, oData
`ifdef MOD_RANGE_CHECK_EN
      , oErr
`endif
   );

   modport slave (
      input  iValid, iMode, iClr, iData0, iData1, iQ, iReady,
      output oReady, oValid, oData
`ifdef MOD_RANGE_CHECK_EN
      , oErr
`endif
   );

endinterface

// File: rtl/mod_addsub_lane.sv
// rtl/mod_addsub_lane.sv - combinational single-lane modular add/sub with one correction step
// Range flag output exists only when MOD_RANGE_CHECK_EN is defined.
module mod_addsub_lane
   import mod_pkg::*;
#(
   parameter int BITWIDTH = 32
) (
   input  logic [BITWIDTH-1:0] a,
   input  logic [BITWIDTH-1:0] b,
   input  logic [BITWIDTH-1:0] acc,
   input  logic [BITWIDTH-1:0] q,
   input  logic [1:0]          mode,
   output logic [BITWIDTH-1:0] r
`ifdef MOD_RANGE_CHECK_EN
   , output logic              err
`endif
);

   logic              is_acc;
   logic              is_sub;
   logic [BITWIDTH:0] x;
   logic [BITWIDTH:0] y;
   logic [BITWIDTH:0] q_ext;
   logic [BITWIDTH:0] sum;
   logic [BITWIDTH:0] dif;
   logic [BITWIDTH:0] sum_corr;
   logic [BITWIDTH:0] dif_corr;

   always_comb begin
      is_acc   = (mode == MOD_ACC_ADD) || (mode == MOD_ACC_SUB);
      is_sub   = (mode == MOD_SUB) || (mode == MOD_ACC_SUB);
      // Accumulate modes feed acc as the left operand and a as the right one.
      x        = is_acc ? {1'b0, acc} : {1'b0, a};
      y        = is_acc ? {1'b0, a}   : {1'b0, b};
      q_ext    = {1'b0, q};
      sum      = x + y;
      dif      = x - y;
      sum_corr = sum - q_ext;
      dif_corr = dif + q_ext;
      if (is_sub) begin
         r = dif[BITWIDTH] ? dif_corr[BITWIDTH-1:0] : dif[BITWIDTH-1:0];
      end else begin
         r = (sum >= q_ext) ? sum_corr[BITWIDTH-1:0] : sum[BITWIDTH-1:0];
      end
   end

`ifdef MOD_RANGE_CHECK_EN
   always_comb begin
      err = (a >= q) || (!is_acc && (b >= q));
   end
`endif

endmodule

// File: rtl/mod_addsub_acc_pipe.sv
// rtl/mod_addsub_acc_pipe.sv - multi-lane modular add/sub/accumulate, two-stage valid/ready pipe
// Per-lane oErr range flags are built only when MOD_RANGE_CHECK_EN is defined.
module mod_addsub_acc_pipe
   import mod_pkg::*;
#(
   parameter int BITWIDTH = 32,
   parameter int LANES    = 4
) (
   input logic                  iClk,
   input logic                  iRst,
   mod_addsub_acc_pipe_if.slave bus
);

   typedef logic [LANES-1:0][BITWIDTH-1:0] lane_vec_t;

   logic      adv;
   logic      accept;
   logic      acc_op;
   lane_vec_t acc_eff;
   lane_vec_t res;

   logic      s1_valid_d, s1_valid_q;
   logic      out_valid_d, out_valid_q;
   lane_vec_t s1_data_d, s1_data_q;
   lane_vec_t out_data_d, out_data_q;
   lane_vec_t acc_d, acc_q;
`ifdef MOD_RANGE_CHECK_EN
   logic [LANES-1:0] err;
   logic [LANES-1:0] s1_err_d, s1_err_q;
   logic [LANES-1:0] out_err_d, out_err_q;
`endif

   always_comb begin
      adv     = !out_valid_q || bus.iReady;
      accept  = bus.iValid && adv;
      acc_op  = (bus.iMode == MOD_ACC_ADD) || (bus.iMode == MOD_ACC_SUB);
      // A clear in the same cycle as an accumulate makes the op start from zero.
      acc_eff = bus.iClr ? '0 : acc_q;
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      localparam int LSB = lane_lsb(k, BITWIDTH);
      mod_addsub_lane #(
         .BITWIDTH(BITWIDTH)
      ) u_lane (
         .a    (bus.iData0[LSB +: BITWIDTH]),
         .b    (bus.iData1[LSB +: BITWIDTH]),
         .acc  (acc_eff[k]),
         .q    (bus.iQ),
         .mode (bus.iMode),
         .r    (res[k])
`ifdef MOD_RANGE_CHECK_EN
         , .err(err[k])
`endif
      );
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_data_d   = s1_data_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      acc_d       = acc_q;
      if (adv) begin
         s1_valid_d  = accept;
         s1_data_d   = res;
         out_valid_d = s1_valid_q;
         out_data_d  = s1_data_q;
      end
      if (bus.iClr) begin
         acc_d = '0;
      end
      if (accept && acc_op) begin
         acc_d = res;
      end
   end

`ifdef MOD_RANGE_CHECK_EN
   always_comb begin
      s1_err_d  = s1_err_q;
      out_err_d = out_err_q;
      if (adv) begin
         s1_err_d  = err;
         out_err_d = s1_err_q;
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         s1_err_q  <= '0;
         out_err_q <= '0;
      end else begin
         s1_err_q  <= s1_err_d;
         out_err_q <= out_err_d;
      end
   end

   assign bus.oErr = out_err_q;
`endif

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         s1_data_q   <= '0;
         out_data_q  <= '0;
         acc_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         s1_data_q   <= s1_data_d;
         out_data_q  <= out_data_d;
         acc_q       <= acc_d;
      end
   end

   assign bus.oReady = adv;
   assign bus.oValid = out_valid_q;
   assign bus.oData  = out_data_q;

endmodule

// File: tb/tb_mod_addsub_acc_pipe.sv
// tb/tb_mod_addsub_acc_pipe.sv - directed table plus randomized scoreboard bench for mod_addsub_acc_pipe
// oErr checks are compiled in when MOD_RANGE_CHECK_EN is defined.
module tb_mod_addsub_acc_pipe;
   import mod_pkg::*;

   localparam int BW = 8;
   localparam int LN = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mod_addsub_acc_pipe_if #(.BITWIDTH(BW), .LANES(LN)) bus ();

   mod_addsub_acc_pipe #(.BITWIDTH(BW), .LANES(LN)) dut (
      .iClk (clk),
      .iRst (rst),
      .bus  (bus.slave)
   );

   typedef struct {
      logic          v;
      logic [1:0]    md;
      logic          clr;
      logic [BW-1:0] a0, a1, b0, b1, e0, e1;
   } vec_t;

   typedef struct {
      logic [LN*BW-1:0] d;
      logic [LN-1:0]    e;
      int               p;
   } item_t;

   int    nvec = 0;
   int    nerr = 0;
   int    cyc  = 0;
   int    acc_m [LN];
   item_t q_exp [$];
   vec_t  tbl [12];

   function automatic vec_t mk(input logic v, input logic [1:0] md, input logic clr,
                               input int a0, input int a1, input int b0, input int b1,
                               input int e0, input int e1);
      vec_t t;
      t.v = v; t.md = md; t.clr = clr;
      t.a0 = BW'(a0); t.a1 = BW'(a1); t.b0 = BW'(b0); t.b1 = BW'(b1);
      t.e0 = BW'(e0); t.e1 = BW'(e1);
      return t;
   endfunction

   // Reference: plain modular arithmetic on integers.
   function automatic int mref(input logic [1:0] md, input int acc, input int a, input int b, input int q);
      int x, y;
      x = md[1] ? acc : a;
      y = md[1] ? a : b;
      if (md[0]) return (x - y + q) % q;
      return (x + y) % q;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic drv(input logic v, input logic [1:0] md, input logic clr,
                      input logic [LN*BW-1:0] a, input logic [LN*BW-1:0] b, input logic [BW-1:0] qq);
      bus.iValid = v;
      bus.iMode  = md;
      bus.iClr   = clr;
      bus.iData0 = a;
      bus.iData1 = b;
      bus.iQ     = qq;
   endtask

   // Entered just after a falling edge with inputs driven; leaves at the next falling edge.
   task automatic step(input logic use_exp, input logic [LN*BW-1:0] ed, input logic [LN-1:0] ee);
      logic  ev, adv, acc_ok;
      item_t it;
      int    r, av, bv, qv;
      #1;
      ev = (q_exp.size() > 0) && (q_exp[0].p <= cyc - 1);
      chk("oValid", 32'(bus.oValid), 32'(ev));
      if (ev) begin
         chk("oData", 32'(bus.oData), 32'(q_exp[0].d));
`ifdef MOD_RANGE_CHECK_EN
         chk("oErr", 32'(bus.oErr), 32'(q_exp[0].e));
`endif
      end
      adv = !ev || bus.iReady;
      chk("oReady", 32'(bus.oReady), 32'(adv));
      acc_ok = bus.iValid && adv;
      if (bus.iClr) begin
         for (int k = 0; k < LN; k++) acc_m[k] = 0;
      end
      if (acc_ok) begin
         qv = int'(bus.iQ);
         for (int k = 0; k < LN; k++) begin
            av = int'(bus.iData0[k*BW +: BW]);
            bv = int'(bus.iData1[k*BW +: BW]);
            r  = mref(bus.iMode, acc_m[k], av, bv, qv);
            it.d[k*BW +: BW] = r[BW-1:0];
            it.e[k] = (av >= qv) || (!bus.iMode[1] && (bv >= qv));
            if (bus.iMode[1]) acc_m[k] = r;
         end
         if (use_exp) begin
            it.d = ed;
            it.e = ee;
         end
         it.p = cyc + 1;
         q_exp.push_back(it);
      end
      if (ev && bus.iReady) void'(q_exp.pop_front());
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      drv(1'b0, MOD_ADD, 1'b0, '0, '0, 8'd17);
      repeat (n) step(1'b0, '0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int qs [4];
      int q;
      logic [LN*BW-1:0] ra, rb;

      tbl[0]  = mk(1'b1, MOD_ADD,     1'b0, 10, 16,  9, 0,  2, 16);
      tbl[1]  = mk(1'b1, MOD_SUB,     1'b0,  3,  5,  5, 3, 15,  2);
      tbl[2]  = mk(1'b1, MOD_ADD,     1'b0, 16,  0, 16, 0, 15,  0);
      tbl[3]  = mk(1'b1, MOD_SUB,     1'b0,  0, 16, 16, 16, 1,  0);
      tbl[4]  = mk(1'b1, MOD_ACC_ADD, 1'b0, 16,  1,  3, 4, 16,  1);
      tbl[5]  = mk(1'b1, MOD_ACC_ADD, 1'b0, 16,  2,  3, 4, 15,  3);
      tbl[6]  = mk(1'b1, MOD_ACC_ADD, 1'b0, 16,  3,  3, 4, 14,  6);
      tbl[7]  = mk(1'b1, MOD_ACC_SUB, 1'b0, 15, 15,  3, 4, 16,  8);
      tbl[8]  = mk(1'b1, MOD_ACC_ADD, 1'b0, 10, 10,  3, 4,  9,  1);
      tbl[9]  = mk(1'b1, MOD_ACC_ADD, 1'b1,  7,  5,  3, 4,  7,  5);
      tbl[10] = mk(1'b0, MOD_ACC_ADD, 1'b1,  0,  0,  0, 0,  0,  0);
      tbl[11] = mk(1'b1, MOD_ACC_ADD, 1'b0,  1,  2,  3, 4,  1,  2);

      for (int k = 0; k < LN; k++) acc_m[k] = 0;
      bus.iReady = 1'b1;
      drv(1'b0, MOD_ADD, 1'b0, '0, '0, 8'd17);

      @(negedge clk);
      #1;
      chk("rst_oValid", 32'(bus.oValid), 32'd0);
      chk("rst_oData",  32'(bus.oData),  32'd0);
      chk("rst_oReady", 32'(bus.oReady), 32'd1);
`ifdef MOD_RANGE_CHECK_EN
      chk("rst_oErr",   32'(bus.oErr),   32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         drv(tbl[i].v, tbl[i].md, tbl[i].clr, {tbl[i].a1, tbl[i].a0}, {tbl[i].b1, tbl[i].b0}, 8'd17);
         step(1'b1, {tbl[i].e1, tbl[i].e0}, 2'b00);
      end
`ifdef MOD_RANGE_CHECK_EN
      drv(1'b1, MOD_ADD, 1'b0, {8'd5, 8'd17}, {8'd5, 8'd0}, 8'd17);
      step(1'b1, {8'd10, 8'd0}, 2'b01);
`endif
      idle(3);

      // Backpressure: downstream stalls while the source keeps offering vectors.
      bus.iReady = 1'b0;
      drv(1'b1, MOD_ACC_ADD, 1'b0, {8'd3, 8'd3}, '0, 8'd17);
      repeat (4) step(1'b0, '0, '0);
      #1;
      chk("bp_full_oReady", 32'(bus.oReady), 32'd0);
      chk("bp_full_oValid", 32'(bus.oValid), 32'd1);
      @(negedge clk);
      bus.iReady = 1'b1;
      idle(4);
      chk("bp_drained", 32'(q_exp.size()), 32'd0);

      // Reset with two vectors in flight.
      drv(1'b1, MOD_ADD, 1'b0, {8'd1, 8'd2}, {8'd3, 8'd4}, 8'd17);
      step(1'b0, '0, '0);
      drv(1'b1, MOD_SUB, 1'b0, {8'd9, 8'd9}, {8'd1, 8'd2}, 8'd17);
      step(1'b0, '0, '0);
      bus.iValid = 1'b0;
      #1;
      chk("pre_rst_oValid", 32'(bus.oValid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_oValid", 32'(bus.oValid), 32'd0);
      chk("mid_rst_oData",  32'(bus.oData),  32'd0);
      q_exp.delete();
      for (int k = 0; k < LN; k++) acc_m[k] = 0;
      @(negedge clk);
      rst = 1'b0;
      drv(1'b1, MOD_ACC_ADD, 1'b0, {8'd4, 8'd4}, '0, 8'd17);
      step(1'b1, {8'd4, 8'd4}, 2'b00);
      idle(3);

      // Randomized traffic, one modulus per phase with the accumulators cleared first.
      qs[0] = 17; qs[1] = 2; qs[2] = 255; qs[3] = int'($urandom_range(3, 254));
      for (int ph = 0; ph < 4; ph++) begin
         q = qs[ph];
         bus.iReady = 1'b1;
         drv(1'b0, MOD_ADD, 1'b1, '0, '0, BW'(q));
         step(1'b0, '0, '0);
         for (int n = 0; n < 150; n++) begin
            for (int k = 0; k < LN; k++) begin
               ra[k*BW +: BW] = BW'($urandom_range(0, q - 1));
               rb[k*BW +: BW] = BW'($urandom_range(0, q - 1));
            end
            bus.iReady = ($urandom_range(0, 3) != 0);
            drv(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 15) == 0), ra, rb, BW'(q));
            step(1'b0, '0, '0);
         end
         bus.iReady = 1'b1;
         idle(4);
         chk("phase_drained", 32'(q_exp.size()), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
